series_adder_stream_mc: RTL and testbench

- Parametrised successor to the fixed 8×32-bit series adder streamer.
- Accepts a packed vector of N operands of W bits over a valid/ready handshake and reduces them serially, LANES operands per cycle. Operands are sign- or zero-extended per transaction.
- Optionally accumulates onto the previous result, then presents an RW-bit result with output backpressure and a wrap flag.
- Sits between the AXI-stream unpacker and the result FIFO in the adder datapath.

---
 rtl/series_adder_stream_mc.sv | 130 +++++++++++++
 tb/tb_series_adder_stream_mc.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/series_adder_stream_mc.sv
// Serial N-operand reducer: accepts a packed operand vector, adds LANES operands per cycle,
// optionally accumulates onto the previous result, and holds the result under backpressure.
module series_adder_stream_mc #(
  parameter int unsigned N     = 8,
  parameter int unsigned W     = 32,
  parameter int unsigned LANES = 1,
  parameter int unsigned RW    = 40
) (
  input  logic            clk,
  input  logic            rst_p,
  input  logic            data_vld,
  output logic            data_rdy,
  input  logic [N*W-1:0]  data_i,
  input  logic            signed_i,
  input  logic            accum_i,
  output logic [RW-1:0]   result_o,
  output logic            result_vld,
  input  logic            result_rdy,
  output logic            ovf_o
);

  localparam int unsigned CntW = $clog2(N);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - LANES);
  localparam logic [CntW-1:0] CntInc  = CntW'(LANES);

  if (N % LANES != 0) begin : g_lanes_chk
    $error("LANES must divide N");
  end
  if (RW < W + $clog2(N)) begin : g_rw_chk
    $error("RW must be at least W + clog2(N)");
  end

  typedef enum logic [1:0] {StIdle, StSum, StHold} state_e;

  state_e           r_state, w_state_next;
  logic [N*W-1:0]   r_data;
  logic             r_signed;
  logic [CntW-1:0]  r_cnt;
  logic [RW-1:0]    r_acc;
  logic [RW-1:0]    r_last;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last_step;
  logic [RW-1:0]    w_sum;
  logic             w_ovf;
  logic [W-1:0]     w_op;
  logic [RW-1:0]    w_ext;
  logic [RW:0]      w_wide;

  assign data_rdy    = (r_state == StIdle) && !rst_p;
  assign result_vld  = (r_state == StHold);
  assign result_o    = r_acc;
  assign ovf_o       = r_ovf;
  assign w_accept    = data_vld && data_rdy;
  assign w_last_step = (r_cnt == LastCnt);

  // Lanes are chained as individual RW-bit adds so overflow is judged on every add.
  always_comb begin
    w_sum  = r_acc;
    w_ovf  = r_ovf;
    w_op   = '0;
    w_ext  = '0;
    w_wide = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      w_op   = r_data[l*W +: W];
      w_ext  = r_signed ? {{(RW-W){w_op[W-1]}}, w_op} : {{(RW-W){1'b0}}, w_op};
      w_wide = {1'b0, w_sum} + {1'b0, w_ext};
      if (r_signed) begin
        w_ovf = w_ovf | ((w_sum[RW-1] == w_ext[RW-1]) && (w_wide[RW-1] != w_sum[RW-1]));
      end else begin
        w_ovf = w_ovf | w_wide[RW];
      end
      w_sum = w_wide[RW-1:0];
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StSum;
      StSum:   if (w_last_step) w_state_next = StHold;
      StHold:  if (result_rdy) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      r_data   <= '0;
      r_signed <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_last   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_data   <= data_i;
            r_signed <= signed_i;
            r_cnt    <= '0;
            r_acc    <= accum_i ? r_last : '0;
            r_ovf    <= 1'b0;
          end
        end
        StSum: begin
          // Consumed operands are shifted out so lanes always read the low slots.
          r_data <= r_data >> (LANES * W);
          r_cnt  <= r_cnt + CntInc;
          r_acc  <= w_sum;
          r_ovf  <= w_ovf;
        end
        StHold: begin
          if (result_rdy) r_last <= r_acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_series_adder_stream_mc.sv
// Directed bench: default, LANES=4, LANES=8 and RW=35 builds share one stimulus stream.
module tb_series_adder_stream_mc;

  logic          clk = 1'b0;
  logic          rst_p;
  logic          data_vld, signed_i, accum_i, result_rdy;
  logic [255:0]  data_i;

  logic          rdy0, vld0, ovf0, rdy4, vld4, ovf4, rdy8, vld8, ovf8, rdy35, vld35, ovf35;
  logic [39:0]   res0, res4, res8;
  logic [34:0]   res35;

  int            errors = 0;
  int            checks = 0;
  int            lat0, lat4, lat8, lat35;
  logic [39:0]   r0, r4, r8;
  logic [34:0]   r35;
  logic          o0, o4, o8, o35;
  logic          rdy_bad, rdy_after;
  logic [255:0]  seq, ones;

  always #5 clk = ~clk;

  series_adder_stream_mc dut0 (
    .clk(clk), .rst_p(rst_p), .data_vld(data_vld), .data_rdy(rdy0), .data_i(data_i),
    .signed_i(signed_i), .accum_i(accum_i), .result_o(res0), .result_vld(vld0),
    .result_rdy(result_rdy), .ovf_o(ovf0)
  );
  series_adder_stream_mc #(.LANES(4)) dut4 (
    .clk(clk), .rst_p(rst_p), .data_vld(data_vld), .data_rdy(rdy4), .data_i(data_i),
    .signed_i(signed_i), .accum_i(accum_i), .result_o(res4), .result_vld(vld4),
    .result_rdy(result_rdy), .ovf_o(ovf4)
  );
  series_adder_stream_mc #(.LANES(8)) dut8 (
    .clk(clk), .rst_p(rst_p), .data_vld(data_vld), .data_rdy(rdy8), .data_i(data_i),
    .signed_i(signed_i), .accum_i(accum_i), .result_o(res8), .result_vld(vld8),
    .result_rdy(result_rdy), .ovf_o(ovf8)
  );
  series_adder_stream_mc #(.RW(35)) dut35 (
    .clk(clk), .rst_p(rst_p), .data_vld(data_vld), .data_rdy(rdy35), .data_i(data_i),
    .signed_i(signed_i), .accum_i(accum_i), .result_o(res35), .result_vld(vld35),
    .result_rdy(result_rdy), .ovf_o(ovf35)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One-cycle accept pulse into all builds, then record each build's first valid result.
  task automatic run_txn(input logic [255:0] ops, input logic sgn, input logic acc);
    data_i = ops; signed_i = sgn; accum_i = acc; data_vld = 1'b1; result_rdy = 1'b1;
    lat0 = -1; lat4 = -1; lat8 = -1; lat35 = -1;
    rdy_bad = 1'b0; rdy_after = 1'b0;
    step;
    data_vld = 1'b0; signed_i = ~sgn; accum_i = ~acc;
    for (int n = 1; n <= 12; n++) begin
      step;
      if (vld0 && lat0 < 0) begin lat0 = n; r0 = res0; o0 = ovf0; end
      if (vld4 && lat4 < 0) begin lat4 = n; r4 = res4; o4 = ovf4; end
      if (vld8 && lat8 < 0) begin lat8 = n; r8 = res8; o8 = ovf8; end
      if (vld35 && lat35 < 0) begin lat35 = n; r35 = res35; o35 = ovf35; end
      if (n <= 8 && rdy0) rdy_bad = 1'b1;
      if (n == 9) rdy_after = rdy0;
    end
  endtask

  task automatic test_reset;
    rst_p = 1'b1; data_vld = 1'b0; signed_i = 1'b0; accum_i = 1'b0; result_rdy = 1'b0;
    data_i = '0;
    step; step;
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", rdy0); end
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", vld0); end
    checks++; if (res0 !== 40'd0) begin errors++; $display("FAIL reset_result: got %0h expected 0", res0); end
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf0); end
    rst_p = 1'b0;
    #1;
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL release_rdy: got %b expected 1", rdy0); end
    step;
  endtask

  task automatic test_unsigned_seq;
    run_txn(seq, 1'b0, 1'b0);
    checks++; if (r0 !== 40'd36) begin errors++; $display("FAIL seq_sum: got %0h expected 24", r0); end
    checks++; if (lat0 !== 8) begin errors++; $display("FAIL seq_latency: got %0d expected 8", lat0); end
    checks++; if (o0 !== 1'b0) begin errors++; $display("FAIL seq_ovf: got %b expected 0", o0); end
    checks++; if (rdy_bad !== 1'b0) begin errors++; $display("FAIL seq_rdy_busy: got %b expected 0", rdy_bad); end
    checks++; if (rdy_after !== 1'b1) begin errors++; $display("FAIL seq_rdy_after: got %b expected 1", rdy_after); end
  endtask

  task automatic test_sign_ext;
    run_txn(ones, 1'b1, 1'b0);
    checks++; if (r0 !== 40'hFF_FFFF_FFF8) begin errors++; $display("FAIL signed_sum: got %0h expected fffffffff8", r0); end
    checks++; if (o0 !== 1'b0) begin errors++; $display("FAIL signed_ovf: got %b expected 0", o0); end
    run_txn(ones, 1'b0, 1'b0);
    checks++; if (r0 !== 40'h07_FFFF_FFF8) begin errors++; $display("FAIL zext_sum: got %0h expected 7fffffff8", r0); end
    checks++; if (o0 !== 1'b0) begin errors++; $display("FAIL zext_ovf: got %b expected 0", o0); end
  endtask

  task automatic test_lanes;
    run_txn(seq, 1'b0, 1'b0);
    checks++; if (r4 !== 40'd36) begin errors++; $display("FAIL lanes4_sum: got %0h expected 24", r4); end
    checks++; if (lat4 !== 2) begin errors++; $display("FAIL lanes4_latency: got %0d expected 2", lat4); end
    checks++; if (r8 !== 40'd36) begin errors++; $display("FAIL lanes8_sum: got %0h expected 24", r8); end
    checks++; if (lat8 !== 1) begin errors++; $display("FAIL lanes8_latency: got %0d expected 1", lat8); end
  endtask

  task automatic test_rw35_accum;
    run_txn(ones, 1'b0, 1'b0);
    checks++; if (r35 !== 35'h7_FFFF_FFF8) begin errors++; $display("FAIL rw35_first: got %0h expected 7fffffff8", r35); end
    checks++; if (o35 !== 1'b0) begin errors++; $display("FAIL rw35_first_ovf: got %b expected 0", o35); end
    run_txn(ones, 1'b0, 1'b1);
    checks++; if (r35 !== 35'h7_FFFF_FFF0) begin errors++; $display("FAIL rw35_accum: got %0h expected 7fffffff0", r35); end
    checks++; if (o35 !== 1'b1) begin errors++; $display("FAIL rw35_accum_ovf: got %b expected 1", o35); end
    checks++; if (r0 !== 40'hF_FFFF_FFF0) begin errors++; $display("FAIL rw40_accum: got %0h expected ffffffff0", r0); end
    run_txn(seq, 1'b0, 1'b0);
    checks++; if (r35 !== 35'd36) begin errors++; $display("FAIL rw35_reset_sum: got %0h expected 24", r35); end
    checks++; if (o35 !== 1'b0) begin errors++; $display("FAIL rw35_reset_ovf: got %b expected 0", o35); end
  endtask

  task automatic test_back_to_back;
    int n;
    result_rdy = 1'b0; data_i = seq; signed_i = 1'b0; accum_i = 1'b0; data_vld = 1'b1;
    step;
    data_vld = 1'b0;
    n = 0;
    while (!vld0 && n < 20) begin step; n++; end
    checks++; if (vld0 !== 1'b1) begin errors++; $display("FAIL bp_vld_rise: got %b expected 1", vld0); end
    for (int i = 0; i < 5; i++) begin
      data_vld = 1'b1; data_i = ones;
      step;
      checks++; if (res0 !== 40'd36) begin errors++; $display("FAIL bp_hold_result: got %0h expected 24", res0); end
      checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL bp_hold_rdy: got %b expected 0", rdy0); end
      checks++; if (vld0 !== 1'b1) begin errors++; $display("FAIL bp_hold_vld: got %b expected 1", vld0); end
    end
    data_vld = 1'b0; result_rdy = 1'b1;
    step;
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL bp_consume_vld: got %b expected 0", vld0); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL bp_consume_rdy: got %b expected 1", rdy0); end
    for (int i = 0; i < 10; i++) step;
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL bp_no_second: got %b expected 0", vld0); end
  endtask

  task automatic test_reset_mid;
    data_i = seq; signed_i = 1'b0; accum_i = 1'b0; result_rdy = 1'b1; data_vld = 1'b1;
    step;
    data_vld = 1'b0;
    step; step; step;
    #2 rst_p = 1'b1;
    #1;
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL mid_reset_vld: got %b expected 0", vld0); end
    checks++; if (res0 !== 40'd0) begin errors++; $display("FAIL mid_reset_result: got %0h expected 0", res0); end
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL mid_reset_rdy: got %b expected 0", rdy0); end
    step; step;
    rst_p = 1'b0;
    step;
    run_txn(seq, 1'b0, 1'b1);
    checks++; if (r0 !== 40'd36) begin errors++; $display("FAIL post_reset_accum: got %0h expected 24", r0); end
    checks++; if (lat0 !== 8) begin errors++; $display("FAIL post_reset_latency: got %0d expected 8", lat0); end
  endtask

  initial begin
    seq  = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    ones = {256{1'b1}};
    test_reset;
    test_unsigned_seq;
    test_sign_ext;
    test_lanes;
    test_rw35_accum;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
